// File: rtl/di_arbiter_pkg.sv
// di_arbiter_pkg: FSM state encodings and sizing helper shared by the DI arbiter slice.
package di_arbiter_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] XFER  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    function automatic int idx_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/di_arbiter_rr_arbiter.sv
// rr_arbiter: picks the first asserted request at or after ptr, wrapping around.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int j;

    // walk from farthest to nearest so the nearest requester overwrites the others
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = IW'(j);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/di_arbiter.sv
// di_arbiter: round-robin burst arbiter sharing one Device Interface among NUM_REQ requesters.
// Stall timeout abort is built only when DI_ARB_TIMEOUT_EN is defined.
module di_arbiter
    import di_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                  if_clock,
    input  logic                  resetb,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_wr,
    input  logic [NUM_REQ*DW-1:0] req_ep,
    input  logic [NUM_REQ*DW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_len,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]    req_wvalid,
    output logic [NUM_REQ-1:0]    gnt,
    output logic                  wtake,
    output logic [DW-1:0]         rdata,
    output logic                  rvalid,
    output logic [NUM_REQ-1:0]    done,
    output logic [NUM_REQ-1:0]    err,
    output logic [DW-1:0]         diEpAddr,
    output logic [DW-1:0]         diRegAddr,
    output logic [DW-1:0]         diRegDataIn,
    output logic                  diWrite,
    output logic                  diRead,
    input  logic [DW-1:0]         diRegDataOut,
    input  logic                  rd_ready,
    input  logic                  wr_ready
);

    localparam int IW = idx_width(NUM_REQ);

    logic [1:0]         state;
    logic [IW-1:0]      ptr, idx, sel_idx;
    logic [NUM_REQ-1:0] sel_gnt;
    logic               sel_any, wr_q, err_q, live, beat, fin, timed_out;
    logic [DW-1:0]      ep_q, addr_q, beats_left;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .req(req),
        .ptr(ptr),
        .gnt(sel_gnt),
        .idx(sel_idx),
        .any(sel_any)
    );

    assign live        = req[idx];
    assign diWrite     = state == XFER && wr_q && live && req_wvalid[idx] && wr_ready;
    assign diRead      = state == XFER && !wr_q && live && rd_ready && beats_left != '0;
    assign beat        = diWrite || diRead;
    assign wtake       = diWrite;
    assign diRegDataIn = diWrite ? req_wdata[idx*DW +: DW] : '0;
    assign diEpAddr    = state == IDLE ? '0 : ep_q;
    assign diRegAddr   = state == IDLE ? '0 : addr_q;
    assign done        = state == DONE ? gnt : '0;
    assign err         = err_q ? done : '0;
    // a read burst ends only once the last beat's data has been returned
    assign fin         = wr_q ? diWrite && beats_left == DW'(1) : beats_left == '0 && rvalid;

`ifdef DI_ARB_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);
    logic [SW-1:0] stall;
    assign timed_out = !beat && stall == SW'(TIMEOUT - 1);
    always_ff @(posedge if_clock) begin
        if (!resetb || state != XFER || beat)
            stall <= '0;
        else
            stall <= stall + 1'b1;
    end
`else
    assign timed_out = TIMEOUT < 0;
`endif

    always_ff @(posedge if_clock) begin
        if (!resetb) begin
            state      <= IDLE;
            ptr        <= '0;
            idx        <= '0;
            gnt        <= '0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            ep_q       <= '0;
            addr_q     <= '0;
            beats_left <= '0;
            rvalid     <= 1'b0;
            rdata      <= '0;
        end else begin
            rvalid <= diRead;
            if (diRead)
                rdata <= diRegDataOut;
            case (state)
                IDLE: if (sel_any) begin
                    state      <= GRANT;
                    idx        <= sel_idx;
                    gnt        <= sel_gnt;
                    wr_q       <= req_wr[sel_idx];
                    ep_q       <= req_ep[sel_idx*DW +: DW];
                    addr_q     <= req_addr[sel_idx*DW +: DW];
                    beats_left <= req_len[sel_idx*DW +: DW];
                    err_q      <= 1'b0;
                end
                GRANT: state <= beats_left == '0 ? DONE : XFER;
                XFER: begin
                    if (beat)
                        beats_left <= beats_left - 1'b1;
                    if (fin)
                        state <= DONE;
                    else if (!live || timed_out) begin
                        state <= DONE;
                        err_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    ptr   <= idx == IW'(NUM_REQ - 1) ? '0 : idx + 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_di_arbiter.sv
// tb_di_arbiter: table-driven cycle vectors plus directed multi-cycle sequences for di_arbiter.
module tb_di_arbiter;

    typedef struct {
        logic [1:0]  req, wr, wv;
        logic        rdr, wrr;
        logic [15:0] dout;
        logic [1:0]  gnt;
        logic        dw, dr, rv;
        logic [15:0] rd;
        logic [1:0]  dn, er;
    } vec_t;

    logic        if_clock = 1'b0;
    logic        resetb;
    logic [1:0]  req, req_wr, req_wvalid, gnt, done, err;
    logic [31:0] req_ep, req_addr, req_len, req_wdata;
    logic        wtake, rvalid, diWrite, diRead, rd_ready, wr_ready;
    logic [15:0] rdata, diEpAddr, diRegAddr, diRegDataIn, diRegDataOut;

    int checks = 0;
    int failures = 0;
    vec_t tbl[17];

    always #5 if_clock = ~if_clock;

    di_arbiter #(.NUM_REQ(2), .DW(16), .TIMEOUT(8)) dut (
        .if_clock(if_clock),
        .resetb(resetb),
        .req(req),
        .req_wr(req_wr),
        .req_ep(req_ep),
        .req_addr(req_addr),
        .req_len(req_len),
        .req_wdata(req_wdata),
        .req_wvalid(req_wvalid),
        .gnt(gnt),
        .wtake(wtake),
        .rdata(rdata),
        .rvalid(rvalid),
        .done(done),
        .err(err),
        .diEpAddr(diEpAddr),
        .diRegAddr(diRegAddr),
        .diRegDataIn(diRegDataIn),
        .diWrite(diWrite),
        .diRead(diRead),
        .diRegDataOut(diRegDataOut),
        .rd_ready(rd_ready),
        .wr_ready(wr_ready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge if_clock);
        #1;
    endtask

    function automatic vec_t mk(input logic [1:0] rq, input logic [1:0] wr, input logic [1:0] wv,
                                input logic rr, input logic wrr, input logic [15:0] dout,
                                input logic [1:0] g, input logic dw, input logic dr, input logic rv,
                                input logic [15:0] rd, input logic [1:0] dn, input logic [1:0] er);
        vec_t v;
        v.req = rq; v.wr = wr; v.wv = wv; v.rdr = rr; v.wrr = wrr; v.dout = dout;
        v.gnt = g; v.dw = dw; v.dr = dr; v.rv = rv; v.rd = rd; v.dn = dn; v.er = er;
        return v;
    endfunction

    task automatic chk_quiet(input string nm);
        chk({nm, " gnt"}, 32'(gnt), 32'h0);
        chk({nm, " diWrite"}, 32'(diWrite), 32'h0);
        chk({nm, " diRead"}, 32'(diRead), 32'h0);
        chk({nm, " diEpAddr"}, 32'(diEpAddr), 32'h0);
        chk({nm, " diRegAddr"}, 32'(diRegAddr), 32'h0);
        chk({nm, " diRegDataIn"}, 32'(diRegDataIn), 32'h0);
        chk({nm, " rdata"}, 32'(rdata), 32'h0);
        chk({nm, " rvalid"}, 32'(rvalid), 32'h0);
        chk({nm, " done"}, 32'(done), 32'h0);
        chk({nm, " err"}, 32'(err), 32'h0);
    endtask

    initial begin
        logic [1:0] seq[4];
        logic [1:0] dn, er;
        int nd, overlap, reads, rvals, strobes, got, at;

        //             req    wr     wv     rdr   wrr   dout        gnt   dw    dr    rv    rdata       done   err
        tbl[0]  = mk(2'b01, 2'b01, 2'b01, 1'b0, 1'b1, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b00);
        tbl[1]  = mk(2'b01, 2'b01, 2'b01, 1'b0, 1'b1, 16'h0000, 2'b01, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b00);
        tbl[2]  = mk(2'b01, 2'b01, 2'b01, 1'b0, 1'b1, 16'h0000, 2'b01, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b00);
        tbl[3]  = mk(2'b01, 2'b01, 2'b01, 1'b0, 1'b1, 16'h0000, 2'b01, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b00);
        tbl[4]  = mk(2'b01, 2'b01, 2'b01, 1'b0, 1'b1, 16'h0000, 2'b01, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b00);
        tbl[5]  = mk(2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 16'h0000, 2'b01, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b01, 2'b00);
        tbl[6]  = mk(2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b00);
        tbl[7]  = mk(2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 16'h0000, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b00);
        tbl[8]  = mk(2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 16'hA001, 2'b10, 1'b0, 1'b1, 1'b0, 16'h0000, 2'b00, 2'b00);
        tbl[9]  = mk(2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b10, 1'b0, 1'b0, 1'b1, 16'hA001, 2'b00, 2'b00);
        tbl[10] = mk(2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 16'hA002, 2'b10, 1'b0, 1'b1, 1'b0, 16'hA001, 2'b00, 2'b00);
        tbl[11] = mk(2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 16'hA003, 2'b10, 1'b0, 1'b1, 1'b1, 16'hA002, 2'b00, 2'b00);
        tbl[12] = mk(2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b10, 1'b0, 1'b0, 1'b1, 16'hA003, 2'b00, 2'b00);
        tbl[13] = mk(2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 16'hA004, 2'b10, 1'b0, 1'b1, 1'b0, 16'hA003, 2'b00, 2'b00);
        tbl[14] = mk(2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 16'h0000, 2'b10, 1'b0, 1'b0, 1'b1, 16'hA004, 2'b00, 2'b00);
        tbl[15] = mk(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b10, 1'b0, 1'b0, 1'b0, 16'hA004, 2'b10, 2'b00);
        tbl[16] = mk(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, 16'hA004, 2'b00, 2'b00);

        resetb = 1'b0; req = '0; req_wr = '0; req_wvalid = '0; rd_ready = 1'b0; wr_ready = 1'b0;
        req_ep = {16'h0011, 16'h0010}; req_addr = {16'h0021, 16'h0020};
        req_len = {16'd4, 16'd3}; req_wdata = {16'h0000, 16'hBEEF}; diRegDataOut = '0;
        tick(); tick();
        #1;
        chk_quiet("reset");
        chk("reset wtake", 32'(wtake), 32'h0);
        resetb = 1'b1;

        // write burst len 3 on req0, then read burst len 4 on req1 with rd_ready gaps
        for (int i = 0; i < 17; i++) begin
            tick();
            req = tbl[i].req; req_wr = tbl[i].wr; req_wvalid = tbl[i].wv;
            rd_ready = tbl[i].rdr; wr_ready = tbl[i].wrr; diRegDataOut = tbl[i].dout;
            #1;
            chk($sformatf("row%0d gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("row%0d diWrite", i), 32'(diWrite), 32'(tbl[i].dw));
            chk($sformatf("row%0d wtake", i), 32'(wtake), 32'(tbl[i].dw));
            chk($sformatf("row%0d diRegDataIn", i), 32'(diRegDataIn), tbl[i].dw ? 32'hBEEF : 32'h0);
            chk($sformatf("row%0d diRead", i), 32'(diRead), 32'(tbl[i].dr));
            chk($sformatf("row%0d rvalid", i), 32'(rvalid), 32'(tbl[i].rv));
            chk($sformatf("row%0d rdata", i), 32'(rdata), 32'(tbl[i].rd));
            chk($sformatf("row%0d done", i), 32'(done), 32'(tbl[i].dn));
            chk($sformatf("row%0d err", i), 32'(err), 32'(tbl[i].er));
        end

        // both requesters held: grants must alternate starting from req0
        req_len = {16'd1, 16'd1}; req_wr = 2'b11; req_wvalid = 2'b11; wr_ready = 1'b1; req = 2'b11;
        nd = 0; overlap = 0;
        for (int c = 0; c < 60 && nd < 4; c++) begin
            tick();
            if ($countones(gnt) > 1) overlap++;
            if (|done) begin
                seq[nd] = done;
                nd++;
                if (nd == 4) req = 2'b00;
            end
        end
        chk("alt bursts seen", 32'(nd), 32'd4);
        chk("alt overlap", 32'(overlap), 32'd0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("alt done%0d", i), 32'(seq[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
        tick();

        // zero-length burst: no strobes, done on the third cycle
        req_len = {16'd1, 16'd0}; req_wr = 2'b01; req_wvalid = 2'b01; req = 2'b01;
        #1;
        chk("len0 c0 done", 32'(done), 32'h0);
        tick();
        chk("len0 c1 gnt", 32'(gnt), 32'h1);
        chk("len0 c1 diWrite", 32'(diWrite), 32'h0);
        tick();
        chk("len0 c2 done", 32'(done), 32'h1);
        chk("len0 c2 err", 32'(err), 32'h0);
        chk("len0 c2 diWrite", 32'(diWrite), 32'h0);
        req = 2'b00;
        tick();

        // req0 drops after 2 of 5 read beats
        req_len = {16'd1, 16'd5}; req_wr = 2'b00; req_wvalid = 2'b00; rd_ready = 1'b1;
        diRegDataOut = 16'hC0DE; req = 2'b01;
        reads = 0; rvals = 0; got = 0; dn = '0; er = '0;
        for (int c = 0; c < 20 && got == 0; c++) begin
            if (reads == 2) req = 2'b00;
            #1;
            reads += int'(diRead);
            rvals += int'(rvalid);
            if (|done) begin
                got = 1; dn = done; er = err;
            end else
                tick();
        end
        chk("drop done seen", 32'(got), 32'd1);
        chk("drop reads", 32'(reads), 32'd2);
        chk("drop rvalids", 32'(rvals), 32'd2);
        chk("drop done", 32'(dn), 32'h1);
        chk("drop err", 32'(er), 32'h1);
        chk("drop rdata", 32'(rdata), 32'hC0DE);
        tick();

        // reset in the middle of a req1 write burst
        req_len = {16'd5, 16'd1}; req_wdata = {16'h1234, 16'hBEEF}; req_wr = 2'b10;
        req_wvalid = 2'b10; rd_ready = 1'b0; wr_ready = 1'b1; req = 2'b10;
        tick();
        chk("rst c1 diEpAddr", 32'(diEpAddr), 32'h0011);
        chk("rst c1 diRegAddr", 32'(diRegAddr), 32'h0021);
        chk("rst c1 diWrite", 32'(diWrite), 32'h0);
        tick();
        chk("rst c2 diWrite", 32'(diWrite), 32'h1);
        chk("rst c2 diRegDataIn", 32'(diRegDataIn), 32'h1234);
        tick();
        chk("rst c3 diWrite", 32'(diWrite), 32'h1);
        resetb = 1'b0;
        tick();
        chk_quiet("midrst");
        resetb = 1'b1; req = 2'b00;
        tick();

        // write stalled by wr_ready low
        req_len = {16'd1, 16'd2}; req_wr = 2'b01; req_wvalid = 2'b01; wr_ready = 1'b0; req = 2'b01;
        got = 0; at = 0; strobes = 0; er = '0;
        for (int c = 0; c < 1000; c++) begin
            #1;
            strobes += int'(diWrite);
            if (|done) begin
                got = 1; at = c; er = err;
                break;
            end
            tick();
        end
        chk("stall strobes", 32'(strobes), 32'd0);
`ifdef DI_ARB_TIMEOUT_EN
        chk("timeout done seen", 32'(got), 32'd1);
        chk("timeout cycle", 32'(at), 32'd10);
        chk("timeout err", 32'(er), 32'h1);
`else
        chk("stall no done", 32'(got), 32'd0);
        chk("stall gnt held", 32'(gnt), 32'h1);
`endif
        req = 2'b00; resetb = 1'b0;
        tick();
        chk_quiet("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
